// File: rtl/level_pkg.sv
// Shared types and default constants for the priority-level scheduler.
// The types are sized for the default configuration of eight levels and 32-bit pc.
package level_pkg;

    localparam int unsigned NUM_LEVELS_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] RET_MAGIC_DEF  = 32'hFFFF_FFFC;

    typedef logic [$clog2(NUM_LEVELS_DEF)-1:0] level_t;

    typedef enum logic [1:0] {
        RUN,
        ENTRY,
        EXIT
    } sched_state_e;

    typedef struct packed {
        level_t                    level;
        logic [DATA_WIDTH_DEF-1:0] pc;
    } stack_entry_t;

endpackage

// File: rtl/level_sched_prio_enc.sv
// Highest-set-bit encoder with a valid flag.
// It is also intended for reuse by the interrupt controller.
module prio_enc #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0]         req,
    output logic [$clog2(Width)-1:0] idx,
    output logic                     valid
);

    localparam int unsigned IW = $clog2(Width);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < Width; i++) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/level_sched.sv
// Priority-level scheduler: picks the active register bank, and saves and restores
// level/pc on preemption and on return.
//
// state | meaning
// RUN   | normal execution; evaluates return and preemption requests
// ENTRY | one cycle: ra of new bank <= RetMagic, redirect to vector, ack pending bit
// EXIT  | one cycle: restored level active, redirect to saved pc
module level_sched
    import level_pkg::*;
#(
    parameter int unsigned          DataWidth = DATA_WIDTH_DEF,
    parameter int unsigned          NumLevels = NUM_LEVELS_DEF,
    parameter logic [DataWidth-1:0] VecBase   = DataWidth'(VEC_BASE_DEF),
    parameter logic [DataWidth-1:0] RetMagic  = DataWidth'(RET_MAGIC_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NumLevels-1:0]         irqPend,
    output logic [NumLevels-1:0]         irqAck,
    input  logic                         retReq,
    input  logic [DataWidth-1:0]         pcIn,
    output logic                         pcLoad,
    output logic [DataWidth-1:0]         pcOut,
    output logic                         busy,
    output logic [$clog2(NumLevels)-1:0] level,
    output logic                         writeRaEn,
    output logic [DataWidth-1:0]         writeRaData,
    output logic                         err
);

    localparam int unsigned LW = $clog2(NumLevels);

    typedef struct packed {
        logic [LW-1:0]        lvl;
        logic [DataWidth-1:0] pc;
    } entry_t;

    sched_state_e  state_q;
    logic [LW-1:0] sp_q;
    logic [LW-1:0] hp;
    logic          hp_valid;
    logic          preempt;
    logic          do_ret;
    logic          do_push;
    entry_t        top;
    entry_t        stack_q [NumLevels-1];

    // Level 0 is thread mode and can never preempt, so its pending bit is masked.
    prio_enc #(.Width(NumLevels)) u_prio_enc (
        .req   (irqPend & ~NumLevels'(1)),
        .idx   (hp),
        .valid (hp_valid)
    );

    always_comb begin
        preempt = (state_q == RUN) && !retReq && hp_valid && (hp > level);
        do_push = preempt && (sp_q != LW'(NumLevels - 1));
        do_ret  = (state_q == RUN) && retReq && (level != '0);
        top     = stack_q[sp_q - LW'(1)];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_q[sp_q] <= '{lvl: level, pc: pcIn};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            sp_q        <= '0;
            level       <= '0;
            irqAck      <= '0;
            pcLoad      <= 1'b0;
            pcOut       <= VecBase;
            busy        <= 1'b0;
            writeRaEn   <= 1'b0;
            writeRaData <= '0;
            err         <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (retReq && !do_ret) begin
                        err <= 1'b1;
                    end else if (do_ret) begin
                        sp_q    <= sp_q - LW'(1);
                        level   <= top.lvl;
                        pcOut   <= top.pc;
                        pcLoad  <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= EXIT;
                    end else if (do_push) begin
                        sp_q        <= sp_q + LW'(1);
                        level       <= hp;
                        pcOut       <= VecBase + (DataWidth'(hp) << 2);
                        pcLoad      <= 1'b1;
                        busy        <= 1'b1;
                        irqAck      <= NumLevels'(1) << hp;
                        writeRaEn   <= 1'b1;
                        writeRaData <= RetMagic;
                        state_q     <= ENTRY;
                    end else if (preempt) begin
                        // Stack full: cannot happen with strictly rising levels.
                        err <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    pcLoad    <= 1'b0;
                    busy      <= 1'b0;
                    irqAck    <= '0;
                    writeRaEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/level_sched.md
Name: level_sched

Overview:
- Priority-level scheduler for the banked register file `rf_stack`.
- Selects the active register bank (`level`) from pending interrupt levels.
- On preemption: saves the preempted level and pc on an internal stack, writes the return marker into the new bank's ra, and redirects the core to the level's vector. On return: pops the stack and restores level and pc.
- Sits between the interrupt pending logic, the core fetch stage and `rf_stack`.

Parameters:
- DataWidth, 32, pc/ra data width
- NumLevels, 8, number of priority levels (level 0 = thread mode, never preempts)
- VecBase, 32'h0000_0100, vector table base; vector of level p = VecBase + 4*p
- RetMagic, 32'hFFFF_FFFC, value written to ra on entry; a jump to it signals return

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- irqPend  in  NumLevels  pending level bits; bit 0 ignored
- irqAck  out  NumLevels  one-hot clear of the taken pending bit, one cycle
- retReq  in  1  single-cycle pulse: core executed a jump to RetMagic
- pcIn  in  DataWidth  pc at which the core resumes if preempted now
- pcLoad  out  1  core must load pcOut next cycle
- pcOut  out  DataWidth  redirect target
- busy  out  1  core stalls (no retire, no regfile write)
- level  out  $clog2(NumLevels)  active bank, to rf_stack.level
- writeRaEn  out  1  to rf_stack.writeRaEn
- writeRaData  out  DataWidth  to rf_stack.writeRaData
- err  out  1  sticky: retReq at level 0

Behaviour:
Reset (asynchronous, while reset=0):
- state=RUN, level=0, stack pointer sp=0.
- All outputs 0 except pcOut=VecBase.
- Stack contents are don't-care.
- A reset asserted in ENTRY or EXIT aborts the operation. No irqAck is emitted.

Stack:
- NumLevels-1 entries of {level, pc}.
- Overflow is impossible because levels strictly increase. Push at sp=NumLevels-1 is a design error: hold state and set err.

Selection:
- hp = index of the highest set bit of irqPend[NumLevels-1:1].
- A preemption is valid when hp > level.

State RUN:
- busy=0.
- If retReq and level!=0: pop the top entry into {rLevel, rPc}, sp-1, next state EXIT.
- If retReq and level==0: ignore the request and set err (sticky until reset).
- Else if a preemption is valid: push {level, pcIn}, sp+1, level<=hp, latch p=hp, next state ENTRY.
- retReq has priority over preemption in the same cycle. The pending level is re-evaluated in the cycle after EXIT.

State ENTRY (exactly 1 cycle), then RUN:
- busy=1, writeRaEn=1, writeRaData=RetMagic.
- level=p, so ra is written into bank p.
- pcLoad=1, pcOut=VecBase+4*p, irqAck[p]=1.

State EXIT (exactly 1 cycle), then RUN:
- busy=1, level<=rLevel.
- pcLoad=1, pcOut=rPc.
- writeRaEn=0.

Outputs and latency:
- All outputs are registered, or decoded from registered state only. No combinational path from irqPend, retReq or pcIn to any output.
- Preemption latency: request seen in RUN at cycle n; ENTRY outputs at cycle n+1; first handler instruction at cycle n+2.
- Return latency: identical timing.
- Back-to-back preemption: a higher level becoming pending during ENTRY is taken in the following RUN cycle, and pushes the vector pc taken from pcIn.
- Arithmetic: the vector offset is zero-extended p shifted left by 2, added modulo 2^DataWidth.

Decomposition:
- Package `level_pkg`:
  - `level_t` = logic[$clog2(NumLevels)-1:0]
  - `sched_state_e` {RUN, ENTRY, EXIT}
  - `stack_entry_t` struct {level_t level; logic[DataWidth-1:0] pc}
  - constants VecBase and RetMagic defaults
- Sub-module `prio_enc`: parameterised highest-set-bit encoder with a valid output. Reusable by the interrupt controller.
- Stack storage stays inline as a register array.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> level=0, busy=0, pcLoad=0, writeRaEn=0, err=0, pcOut=32'h100. Assert reset mid-ENTRY -> all outputs return to reset values immediately.
- Preempt: level 0, pcIn=32'h2000, irqPend=8'b0000_0100 ->
  - next cycle: level=2, writeRaEn=1, writeRaData=32'hFFFF_FFFC, pcOut=32'h108, pcLoad=1, irqAck=8'b0000_0100, busy=1.
  - rf_stack bank 2 ra reads 32'hFFFF_FFFC.
- Nesting: at level 2, pcIn=32'h300, irqPend=8'b0010_0000 -> level=5, pcOut=32'h114. Then retReq -> EXIT with level=2, pcOut=32'h300. Then retReq -> level=0, pcOut=32'h2000.
- No preempt: at level 5, irqPend=8'b0001_0000 -> no state change, irqAck=0. After returning to level 2 -> level 4 taken, pcOut=32'h110.
- Simultaneous: at level 2 with stack {0, 32'h2000}, retReq=1 and irqPend bit 6 set in the same cycle -> EXIT first (level=0, pcOut=32'h2000), then ENTRY to level 6 (pcOut=32'h118).
- Error: retReq at level 0 -> err=1 and stays 1; level, sp and pcLoad unchanged.
